// File: rtl/base58_ascii_decoder.sv
// Streaming Base-58 ASCII decoder: accumulates MSD-first characters over a
// valid/ready handshake and presents the 8-bit word value with sticky error flags.
module base58_ascii_decoder #(
  parameter int MAX_DIGITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_value,
  output logic       out_err_char,
  output logic       out_err_ovf
);

  localparam int ACC_W = $clog2(58 ** MAX_DIGITS);
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state, state_next;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   count;
  logic               err_char;
  logic               ovf;

  logic               accept;
  logic               char_ok;
  logic [5:0]         digit;
  logic [ACC_W-1:0]   acc_next;

  // Returns {in_alphabet, digit}; characters outside the alphabet decode as digit 0.
  function automatic logic [6:0] char_to_digit(input logic [7:0] c);
    logic [7:0] d;
    logic       ok;
    d  = 8'd0;
    ok = 1'b1;
    if      (c >= 8'h31 && c <= 8'h39) d = c - 8'd49;
    else if (c >= 8'h41 && c <= 8'h48) d = c - 8'd56;
    else if (c >= 8'h4A && c <= 8'h4E) d = c - 8'd57;
    else if (c >= 8'h50 && c <= 8'h5A) d = c - 8'd58;
    else if (c >= 8'h61 && c <= 8'h6B) d = c - 8'd64;
    else if (c >= 8'h6D && c <= 8'h7A) d = c - 8'd65;
    else ok = 1'b0;
    return {ok, d[5:0]};
  endfunction

  // Shift-add multiply; the accumulator width guarantees no wrap while count < MAX_DIGITS.
  function automatic logic [ACC_W-1:0] mul58(input logic [ACC_W-1:0] a);
    return (a << 5) + (a << 4) + (a << 3) + (a << 1);
  endfunction

  assign {char_ok, digit} = char_to_digit(in_char);
  assign accept           = in_valid && in_ready;
  assign acc_next         = mul58(acc) + {{(ACC_W-6){1'b0}}, digit};

  // Accumulator and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      err_char <= 1'b0;
      ovf      <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc      <= '0;
        count    <= '0;
        err_char <= 1'b0;
        ovf      <= 1'b0;
      end
    end else if (accept) begin
      if (count < CNT_W'(MAX_DIGITS)) begin
        acc   <= acc_next;
        count <= count + CNT_W'(1);
        if (acc_next > ACC_W'(255)) ovf <= 1'b1;
      end else begin
        ovf <= 1'b1;
      end
      if (!char_ok) err_char <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM: if (accept && in_last) state_next = HOLD;
      HOLD:  if (out_ready)         state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    in_ready     = (state == ACCUM);
    out_valid    = (state == HOLD);
    out_value    = (state == HOLD) ? acc[7:0] : 8'd0;
    out_err_char = (state == HOLD) && err_char;
    out_err_ovf  = (state == HOLD) && ovf;
  end

endmodule

// File: tb/tb_base58_ascii_decoder.sv
// Scoreboard bench for base58_ascii_decoder: directed words push expected
// results; a monitor compares every out_valid/out_ready handshake.
module tb_base58_ascii_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_value;
  logic       out_err_char;
  logic       out_err_ovf;

  typedef struct packed {
    logic [7:0] value;
    logic       ec;
    logic       eo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  base58_ascii_decoder #(.MAX_DIGITS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_err_char(out_err_char), .out_err_ovf(out_err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: one handshake per HOLD cycle with out_ready high
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_value",    int'(out_value),    int'(e.value));
        check("out_err_char", int'(out_err_char), int'(e.ec));
        check("out_err_ovf",  int'(out_err_ovf),  int'(e.eo));
      end
    end
  end

  task automatic send_char(input logic [7:0] c, input logic last);
    int waited;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input string s, input int v, input bit ec, input bit eo);
    exp_q.push_back('{value: 8'(v), ec: ec, eo: eo});
    for (int i = 0; i < s.len(); i++)
      send_char(s[i], (i == s.len() - 1));
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  int'(in_ready),     1);
    check("rst_out_valid", int'(out_valid),    0);
    check("rst_out_value", int'(out_value),    0);
    check("rst_err_char",  int'(out_err_char), 0);
    check("rst_err_ovf",   int'(out_err_ovf),  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loopback words
    send_word("138", 123, 0, 0);
    send_word("13D", 128, 0, 0);
    send_word("15E", 245, 0, 0);
    send_word("11D", 12,  0, 0);
    // Overflow and boundary
    send_word("1zz", 35,  0, 1);
    send_word("5Q",  255, 0, 0);
    send_word("z",   57,  0, 0);
    send_word("5R",  0,   0, 1);
    // Invalid characters, single char, alphabet edges
    send_word("10A", 9,   1, 0);
    send_word("1",   0,   0, 0);
    send_word("Il",  0,   1, 0);
    send_word("km",  43*58+44 - 256*9, 0, 1);
    send_word("HJ",  16*58+17 - 256*3, 0, 1);
    send_word("NP",  21*58+22 - 256*4, 0, 1);
    // Over-length word: fourth digit ignored
    send_word("1118", 0,  0, 1);
    drain();

    // Backpressure: result held stable, input blocked
    out_ready = 1'b0;
    send_word("138", 123, 0, 0);
    exp_q.push_back('{value: 8'd1, ec: 1'b0, eo: 1'b0});
    in_valid = 1'b1; in_char = "2"; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_value", int'(out_value), 123);
      check("bp_in_ready",  int'(in_ready),  0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_accept_after_pulse", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    drain();

    // Reset mid-word discards the partial word
    send_char("1", 1'b0);
    send_char("3", 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send_word("11D", 12, 0, 0);
    drain();

    // Asynchronous reset during HOLD drops the pending result
    out_ready = 1'b0;
    send_char("1", 1'b0);
    send_char("5", 1'b0);
    send_char("E", 1'b1);
    check("hold_before_rst", int'(out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_in_ready",  int'(in_ready),  1);
    check("async_rst_out_value", int'(out_value), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    s = "2z";
    send_word(s, 1*58+57, 0, 0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/base58_ascii_decoder.md
# base58_ascii_decoder

Streaming Base-58 ASCII-to-binary decoder that sits directly downstream of the combinational Base-58 encoder. It accepts encoded characters one at a time over a valid/ready handshake, in the same alphabet and most-significant-digit-first order the encoder emits. It accumulates the word value and presents the decoded 8-bit number with error flags. Its main uses are loopback checking of the encoder and decoding Base-58 text from a serial source.

## Interface

Parameters:
- MAX_DIGITS, 3, maximum characters per word; the accumulator is sized to hold 58^MAX_DIGITS−1 (18 bits for the default).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_char/in_last valid
- in_ready  output  1  decoder can accept a character
- in_char  input  8  ASCII Base-58 character, most significant digit first
- in_last  input  1  final character of the word
- out_valid  output  1  decoded word available
- out_ready  input  1  consumer takes the word
- out_value  output  8  decoded value, low 8 bits of the accumulator
- out_err_char  output  1  word contained a character outside the alphabet
- out_err_ovf  output  1  value exceeded 255, or the word was longer than MAX_DIGITS

## Operation

- Alphabet mapping (combinational):
  - '1'–'9' → 0–8
  - 'A'–'H' → 9–16
  - 'J'–'N' → 17–21
  - 'P'–'Z' → 22–32
  - 'a'–'k' → 33–43
  - 'm'–'z' → 44–57
  - Anything else ('0', 'I', 'O', 'l', non-printables) is invalid and maps to digit 0.
- State machine, two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- ACCUM, on each accepted character (in_valid & in_ready):
  - If count < MAX_DIGITS: acc ← acc*58 + digit, count ← count+1.
  - If count == MAX_DIGITS: acc is unchanged and ovf is set (over-length word).
  - If the character is invalid: err_char is set; it still counts and accumulates as digit 0.
  - If the new acc > 255: ovf is set.
  - err_char and ovf are sticky for the rest of the word.
  - If in_last is set: go to HOLD.
- HOLD:
  - out_value = acc[7:0]; flags are driven from the sticky bits.
  - Outputs stay stable while out_ready=0.
  - On out_ready=1: clear acc, count, err_char and ovf, then go to ACCUM.
- Leading '1' characters are zero digits and need no special casing.
- A word is always at least one character, because in_last travels with a character.
- Arithmetic: the accumulator is exactly wide enough for MAX_DIGITS digits, so it never wraps. The multiply by 58 is done as (acc<<5)+(acc<<4)+(acc<<3)+(acc<<1).

## Timing

- Reset, asynchronous, takes effect immediately on rst high:
  - State returns to ACCUM; acc=0, count=0, err_char=0, ovf=0.
  - Outputs: in_ready=1, out_valid=0, out_value=0, out_err_char=0, out_err_ovf=0.
  - A reset in the middle of a word discards the partial word.
  - A reset during HOLD drops the pending result.
- Throughput: one character per cycle while in ACCUM.
- Latency: out_valid rises on the clock edge that accepts the in_last character, so it is seen the cycle after that character was presented.
- in_ready is low for the whole of HOLD, so input is blocked until the result is consumed.
- The minimum gap between words is one cycle: the out_ready handshake cycle.
- in_ready and out_valid are registered state decodes; there is no combinational path from out_ready to in_ready.
- When in_valid is low, nothing changes in ACCUM.

## Test plan

- Loopback of the encoder's characters, in_last on the third character of each word, out_ready held at 1:
  - "138" → out_value=123, no flags
  - "13D" → out_value=128, no flags
  - "15E" → out_value=245, no flags
  - "11D" → out_value=12, no flags
- Overflow: "1zz" (3363) → out_err_ovf=1, out_value=35. "5Q" (255) → out_value=255, no flags.
- Invalid character: "10A" → out_err_char=1, out_value=9. Single "1" with in_last → out_value=0.
- Over-length word: "1118" with in_last on the fourth character → out_err_ovf=1, out_value=0; the fourth digit is ignored.
- Backpressure: out_ready=0 for 5 cycles after "138" → out_valid, out_value=123 and in_ready=0 stay stable. Next word accepted only after the out_ready pulse.
- Reset mid-word: "13" then rst for 1 cycle, then "11D" → out_value=12, no flags, no stale result emitted.
